// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned MAX_DATA_BITS = 9;

  // Expected parity bit for a zero-extended payload.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// Synchronous show-ahead FIFO; the head entry is always visible on dout.
module uart_rx_sfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Asynchronous serial receiver with false-start rejection, frame/parity checking
// and a show-ahead receive FIFO with sticky overrun reporting.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2604,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RX,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rdy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  rx_state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic                    par_bad_q, par_bad_d;
  logic                    frame_err_q, frame_err_d;
  logic                    parity_err_q, parity_err_d;
  logic                    overrun_q, overrun_d;

  logic rxs;
  logic tick;
  logic push_c;
  logic frame_set_c;
  logic parity_set_c;
  logic fifo_empty;
  logic fifo_full;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], RX};
  assign rxs    = sync_q[SYNC_STAGES-1];
  assign tick   = (baud_q == '0) && (state_q != IDLE) && (state_q != BREAK);

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    push_c       = 1'b0;
    frame_set_c  = 1'b0;
    parity_set_c = 1'b0;

    if ((state_q != IDLE) && (state_q != BREAK)) begin
      baud_d = tick ? BAUD_W'(CLK_DIV - 1) : baud_q - BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          baud_d    = BAUD_W'(CLK_DIV / 2 - 1);
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_bad_d = (rxs != parity_calc(MAX_DATA_BITS'(shift_q), 1'(PARITY_ODD)));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs) begin
            push_c       = !par_bad_q;
            parity_set_c = par_bad_q;
            state_d      = IDLE;
          end else begin
            frame_set_c  = 1'b1;
            state_d      = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sticky flags: a same-cycle set beats clr_err.
    frame_err_d  = (frame_err_q && !clr_err) || frame_set_c;
    parity_err_d = (parity_err_q && !clr_err) || parity_set_c;
    overrun_d    = (overrun_q && !clr_err) || (push_c && fifo_full && !rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= '1;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      baud_q       <= baud_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_sfifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (rd_en),
    .din   (shift_q),
    .dout  (rx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  assign rdy        = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: an 8N1 instance and an even-parity instance,
// each checked against a frame-level queue model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned DB      = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LAT0    = SYNC_STAGES + 1 + CLK_DIV / 2 + (DB + 0 + 1) * CLK_DIV;
  localparam int unsigned LAT1    = SYNC_STAGES + 1 + CLK_DIV / 2 + (DB + 1 + 1) * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       rd0 = 1'b0, rd1 = 1'b0;
  logic       clr0 = 1'b0, clr1 = 1'b0;
  logic [7:0] data0, data1;
  logic       rdy0, rdy1;
  logic [2:0] cnt0, cnt1;
  logic       fe0, fe1, pe0, pe1, ov0, ov1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       mfe[2], mpe[2], mov[2];
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(DB), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .RX(rx0), .rd_en(rd0), .clr_err(clr0),
    .rx_data(data0), .rdy(rdy0), .count(cnt0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
  );

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .RX(rx1), .rd_en(rd1), .clr_err(clr1),
    .rx_data(data1), .rdy(rdy1), .count(cnt1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic set_rx(input int ch, input logic b);
    if (ch == 0) rx0 = b; else rx1 = b;
  endtask

  task automatic set_rd(input int ch, input logic b);
    if (ch == 0) rd0 = b; else rd1 = b;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      mfe[i] = 1'b0; mpe[i] = 1'b0; mov[i] = 1'b0;
    end
  endtask

  // Frame-level outcome: bad stop -> frame error, bad parity -> parity error,
  // else enqueue unless full (a same-cycle pop frees the slot first).
  task automatic model_frame(input int ch, input logic [7:0] d, input logic par,
                             input logic stp, input bit pop_same);
    logic good_par;
    int   sz;
    good_par = (ch == 0) || (par == (^d));
    if (pop_same) begin
      if (ch == 0 && q0.size() > 0) void'(q0.pop_front());
      if (ch == 1 && q1.size() > 0) void'(q1.pop_front());
    end
    sz = (ch == 0) ? q0.size() : q1.size();
    if (!stp) mfe[ch] = 1'b1;
    else if (!good_par) mpe[ch] = 1'b1;
    else if (sz < DEPTH) begin
      if (ch == 0) q0.push_back(d); else q1.push_back(d);
    end else mov[ch] = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic par,
                            input logic stp, input bit pop_same);
    set_rx(ch, 1'b0);
    wait_cycles(CLK_DIV);
    for (int i = 0; i < DB; i++) begin
      set_rx(ch, d[i]);
      wait_cycles(CLK_DIV);
    end
    if (ch == 1) begin
      set_rx(ch, par);
      wait_cycles(CLK_DIV);
    end
    set_rx(ch, stp);
    wait_cycles(CLK_DIV);
    if (!stp) wait_cycles(40);
    set_rx(ch, 1'b1);
    wait_cycles(4);
    model_frame(ch, d, par, stp, pop_same);
  endtask

  // rd_en is raised for exactly the cycle whose edge registers the push.
  task automatic frame_pop_same(input int ch, input logic [7:0] d);
    int lat;
    lat = (ch == 0) ? LAT0 : LAT1;
    fork
      send_frame(ch, d, ^d, 1'b1, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        #1 set_rd(ch, 1'b1);
        @(posedge clk);
        #1 set_rd(ch, 1'b0);
      end
    join
  endtask

  task automatic pop(input int ch);
    set_rd(ch, 1'b1);
    wait_cycles(1);
    set_rd(ch, 1'b0);
    if (ch == 0 && q0.size() > 0) void'(q0.pop_front());
    if (ch == 1 && q1.size() > 0) void'(q1.pop_front());
  endtask

  task automatic clear_err(input int ch);
    if (ch == 0) clr0 = 1'b1; else clr1 = 1'b1;
    wait_cycles(1);
    clr0 = 1'b0;
    clr1 = 1'b0;
    mfe[ch] = 1'b0; mpe[ch] = 1'b0; mov[ch] = 1'b0;
  endtask

  task automatic check_outputs(input int ch, input string tag);
    logic [7:0] d, head;
    logic       r, fe, pe, ov;
    logic [2:0] c;
    int         sz;
    @(negedge clk);
    if (ch == 0) begin
      d = data0; r = rdy0; c = cnt0; fe = fe0; pe = pe0; ov = ov0;
      sz = q0.size(); head = (sz != 0) ? q0[0] : 8'h00;
    end else begin
      d = data1; r = rdy1; c = cnt1; fe = fe1; pe = pe1; ov = ov1;
      sz = q1.size(); head = (sz != 0) ? q1[0] : 8'h00;
    end
    check({tag, ".rdy"}, 32'(r), 32'(sz != 0));
    check({tag, ".count"}, 32'(c), 32'(sz));
    if (sz != 0) check({tag, ".rx_data"}, 32'(d), 32'(head));
    check({tag, ".frame_err"}, 32'(fe), 32'(mfe[ch]));
    check({tag, ".parity_err"}, 32'(pe), 32'(mpe[ch]));
    check({tag, ".overrun"}, 32'(ov), 32'(mov[ch]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         ch;
    logic [7:0] d;
    logic       stp, par;

    model_reset();
    wait_cycles(3);
    check("rst.rx_data0", 32'(data0), 32'h0);
    check("rst.rx_data1", 32'(data1), 32'h0);
    check_outputs(0, "rst0");
    check_outputs(1, "rst1");
    rst_n = 1'b1;
    wait_cycles(3);

    // First frame: exact latency from start-bit edge to rdy.
    n = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      begin
        while (!rdy0 && n < 400) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
    join
    check("latency", 32'(n), 32'(LAT0));
    check_outputs(0, "a5");
    pop(0);
    check_outputs(0, "a5_pop");

    // False start: short low pulse.
    rx0 = 1'b0;
    wait_cycles(4);
    rx0 = 1'b1;
    wait_cycles(40);
    check_outputs(0, "false_start");

    // Framing error, BREAK hold, recovery.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_outputs(0, "frame_err");
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
    check_outputs(0, "after_break");
    pop(0);
    clear_err(0);
    check_outputs(0, "clr_fe");

    // Even parity.
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    check_outputs(1, "par_ok");
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
    check_outputs(1, "par_bad");
    pop(1);
    clear_err(1);
    check_outputs(1, "clr_pe");

    // Overrun with five frames and no reads.
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b0);
    check_outputs(0, "overrun");
    for (int i = 0; i < 4; i++) begin
      pop(0);
      check_outputs(0, "drain");
    end
    clear_err(0);

    // Full FIFO: push with same-cycle pop is kept, no overrun.
    for (int i = 0; i < 4; i++) send_frame(0, 8'($urandom), 1'b0, 1'b1, 1'b0);
    frame_pop_same(0, 8'($urandom));
    check_outputs(0, "full_pushpop");
    for (int i = 0; i < 4; i++) begin
      pop(0);
      check_outputs(0, "drain2");
    end
    // Empty FIFO: same-cycle pop is ignored, push lands.
    frame_pop_same(0, 8'h9E);
    check_outputs(0, "empty_pushpop");
    pop(0);

    // Random traffic on both channels.
    for (int i = 0; i < 14; i++) begin
      ch  = int'($urandom_range(1, 0));
      d   = 8'($urandom);
      stp = ($urandom_range(5, 0) != 0);
      par = (^d) ^ ($urandom_range(3, 0) == 0);
      send_frame(ch, d, par, stp, 1'b0);
      check_outputs(ch, "rand");
      if ($urandom_range(1, 0) == 1) begin
        pop(ch);
        check_outputs(ch, "rand_pop");
      end
      if ($urandom_range(3, 0) == 0) begin
        clear_err(ch);
        check_outputs(ch, "rand_clr");
      end
    end

    // Reset in the middle of data bit 3.
    d = 8'($urandom);
    rx0 = 1'b0;
    wait_cycles(CLK_DIV);
    for (int i = 0; i < 3; i++) begin
      rx0 = d[i];
      wait_cycles(CLK_DIV);
    end
    rx0 = d[3];
    wait_cycles(CLK_DIV / 2);
    rst_n = 1'b0;
    rx0 = 1'b1;
    model_reset();
    wait_cycles(3);
    check("midrst.rx_data0", 32'(data0), 32'h0);
    check_outputs(0, "midrst0");
    check_outputs(1, "midrst1");
    rst_n = 1'b1;
    wait_cycles(3);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b0);
    check_outputs(0, "c3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
